// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity selectors and the legal
// prescale values used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_ODD  = 1'b1;
   localparam logic PAR_EVEN = 1'b0;

   localparam logic [5:0] PRESC_8  = 6'd8;
   localparam logic [5:0] PRESC_16 = 6'd16;
   localparam logic [5:0] PRESC_32 = 6'd32;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// 6-bit loadable down-counter that times one serial bit; tick is high while
// the count sits at zero.
module uart_tx_bit_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       en,
   input  logic [5:0] load_val,
   output logic       tick
);

   logic [5:0] count_q;
   logic [5:0] count_d;

   // Load wins over counting; the counter parks at zero until reloaded.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != 6'd0)) begin
         count_d = count_q - 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 6'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = (count_q == 6'd0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one stop bit; every bit lasts the prescale value latched at accept.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            prescale,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

   uart_state_e           state_q, state_d;
   logic                  tx_out_q, tx_out_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [5:0]            presc_q, presc_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;

   logic                  timer_load;
   logic [5:0]            timer_val;
   logic                  tick;

   uart_tx_bit_timer u_bit_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .en       (state_q != ST_IDLE),
      .load_val (timer_val),
      .tick     (tick)
   );

   // Handshake: DATA_VALID is accepted only at an edge where the FSM is IDLE
   // (busy=0 acts as ready); requests seen while busy=1 are dropped, not queued.
   always_comb begin
      state_d    = state_q;
      tx_out_d   = tx_out_q;
      busy_d     = busy_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      presc_d    = presc_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      timer_load = 1'b0;
      timer_val  = presc_q - 6'd1;

      case (state_q)
         ST_IDLE: begin
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
            if (DATA_VALID) begin
               shift_d    = P_DATA;
               presc_d    = prescale;
               par_en_d   = PAR_EN;
               par_bit_d  = (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
               bit_cnt_d  = '0;
               state_d    = ST_START;
               tx_out_d   = 1'b0;
               busy_d     = 1'b1;
               timer_load = 1'b1;
               timer_val  = prescale - 6'd1;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d    = ST_DATA;
               tx_out_d   = shift_q[0];
               bit_cnt_d  = '0;
               timer_load = 1'b1;
            end
         end
         ST_DATA: begin
            if (tick) begin
               timer_load = 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  if (par_en_q) begin
                     state_d  = ST_PARITY;
                     tx_out_d = par_bit_q;
                  end else begin
                     state_d  = ST_STOP;
                     tx_out_d = 1'b1;
                  end
               end else begin
                  // Next bit is presented from shift_q[1] in the same edge the register shifts.
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shift_d   = shift_q >> 1;
                  tx_out_d  = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d    = ST_STOP;
               tx_out_d   = 1'b1;
               timer_load = 1'b1;
            end
         end
         ST_STOP: begin
            if (tick) begin
               state_d  = ST_IDLE;
               tx_out_d = 1'b1;
               busy_d   = 1'b0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tx_out_q  <= 1'b1;
         busy_q    <= 1'b0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         presc_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_out_q  <= tx_out_d;
         busy_q    <= busy_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         presc_q   <= presc_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
      end
   end

   assign TX_OUT = tx_out_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a per-cycle waveform model of {busy, TX_OUT} built from
// the frame rules, plus hand-computed frame literals for directed cases.
module tb_uart_tx;

   logic       clk;
   logic       rst_n;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] prescale;
   logic       TX_OUT;
   logic       busy;

   int n_checks = 0;
   int n_err    = 0;

   logic [1:0] exp_q[$];
   logic [1:0] cur_exp = 2'b01;
   logic       chk_en  = 1'b0;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .prescale   (prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   // One entry per clock after an edge: {busy, tx}. A frame is each line bit
   // repeated for its bit time, then one idle entry for the edge leaving STOP.
   task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps);
      int   p;
      logic line_bits[$];
      p = (ps == 6'd0) ? 64 : int'(ps);
      line_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) line_bits.push_back(d[i]);
      if (pe) line_bits.push_back(pt ? ~(^d) : (^d));
      line_bits.push_back(1'b1);
      foreach (line_bits[k])
         for (int c = 0; c < p; c++) exp_q.push_back({1'b1, line_bits[k]});
      exp_q.push_back(2'b01);
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         cur_exp = 2'b01;
      end else begin
         if (exp_q.size() == 0 && DATA_VALID === 1'b1)
            push_frame(P_DATA, PAR_EN, PAR_TYP, prescale);
         if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
         else cur_exp = 2'b01;
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         n_checks++;
         if ({busy, TX_OUT} !== cur_exp) begin
            n_err++;
            $display("FAIL line_cmp t=%0t {busy,tx} got %b expected %b", $time, {busy, TX_OUT}, cur_exp);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a negedge with the DUT idle; returns at the negedge after accept.
   task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] ps);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      prescale   = ps;
      DATA_VALID = 1'b1;
      @(negedge clk);
      DATA_VALID = 1'b0;
      check("start_latency", {busy, TX_OUT}, 2'b10);
   endtask

   // Samples the middle of each bit while busy; optionally perturbs inputs mid-frame.
   task automatic watch_frame(input int p, input int chg_at,
                              output logic [10:0] bits, output int cyc);
      cyc  = 0;
      bits = '1;
      while (busy === 1'b1 && cyc < 2000) begin
         if ((cyc % p) == p / 2) bits[cyc / p] = TX_OUT;
         if (cyc == chg_at) begin
            P_DATA   = 8'hFF;
            PAR_EN   = 1'b1;
            PAR_TYP  = 1'b1;
            prescale = 6'd16;
         end
         cyc++;
         @(negedge clk);
      end
      check("frame_timeout", {31'd0, cyc >= 2000}, 32'd0);
   endtask

   task automatic wait_idle(input string name);
      int cnt;
      cnt = 0;
      while (busy === 1'b1 && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      check(name, {31'd0, cnt >= 2000}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [10:0] bits;
      int          cyc;
      int          gap;

      rst_n      = 1'b0;
      P_DATA     = 8'h00;
      DATA_VALID = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      prescale   = 6'd8;
      repeat (3) @(negedge clk);
      check("reset_tx", {31'd0, TX_OUT}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      // 1: A5, prescale 8, no parity
      start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
      watch_frame(8, -1, bits, cyc);
      check("t1_bits", {22'd0, bits[9:0]}, 32'h34A);
      check("t1_busy_len", cyc, 80);

      // 2: 03, prescale 16, odd then even parity
      start_frame(8'h03, 1'b1, 1'b1, 6'd16);
      watch_frame(16, -1, bits, cyc);
      check("t2_par_odd", {31'd0, bits[9]}, 32'd1);
      check("t2_busy_len", cyc, 176);
      start_frame(8'h03, 1'b1, 1'b0, 6'd16);
      watch_frame(16, -1, bits, cyc);
      check("t2_par_even", {31'd0, bits[9]}, 32'd0);
      check("t2e_busy_len", cyc, 176);

      // 3: 07, prescale 32, even parity; decode the line like a receiver would
      start_frame(8'h07, 1'b1, 1'b0, 6'd32);
      watch_frame(32, -1, bits, cyc);
      check("t3_par", {31'd0, bits[9]}, 32'd1);
      check("t3_rx_data", {24'd0, bits[8:1]}, 32'h07);
      check("t3_rx_stop", {31'd0, bits[10]}, 32'd1);
      check("t3_busy_len", cyc, 352);

      // prescale 0 wraps to 64 clocks per bit
      start_frame(8'h5A, 1'b0, 1'b0, 6'd0);
      watch_frame(64, -1, bits, cyc);
      check("p0_busy_len", cyc, 640);

      // 4a: pulse while busy is dropped
      start_frame(8'h00, 1'b0, 1'b0, 6'd8);
      repeat (20) @(negedge clk);
      P_DATA     = 8'hFF;
      DATA_VALID = 1'b1;
      @(negedge clk);
      DATA_VALID = 1'b0;
      wait_idle("t4_wait_idle");
      repeat (16) @(negedge clk);
      check("t4_dropped_busy", {31'd0, busy}, 32'd0);
      check("t4_dropped_tx", {31'd0, TX_OUT}, 32'd1);

      // 4b: held request starts one clock after busy falls
      start_frame(8'h00, 1'b0, 1'b0, 6'd8);
      P_DATA     = 8'h55;
      DATA_VALID = 1'b1;
      wait_idle("t4_hold_idle");
      gap = 0;
      while (busy !== 1'b1 && gap < 10) begin
         @(negedge clk);
         gap++;
      end
      DATA_VALID = 1'b0;
      check("t4_hold_gap", gap, 1);
      watch_frame(8, -1, bits, cyc);
      check("t4_hold_bits", {22'd0, bits[9:0]}, 32'h2AA);
      check("t4_hold_len", cyc, 80);

      // 5: inputs changed mid-frame do not affect the frame
      start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
      watch_frame(8, 20, bits, cyc);
      check("t5_bits", {22'd0, bits[9:0]}, 32'h34A);
      check("t5_busy_len", cyc, 80);
      prescale = 6'd8;
      PAR_EN   = 1'b0;
      repeat (2) @(negedge clk);

      // 6: one-clock reset during data bit 3
      start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
      repeat (33) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t6_rst_tx", {31'd0, TX_OUT}, 32'd1);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      start_frame(8'h3C, 1'b0, 1'b0, 6'd8);
      watch_frame(8, -1, bits, cyc);
      check("t6_bits", {22'd0, bits[9:0]}, 32'h278);
      check("t6_busy_len", cyc, 80);

      repeat (4) @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter that produces the frames consumed by the UART receiver on the same oversampled clock.
- Takes one byte per handshake and emits start, 8 data bits LSB first, optional parity, then one stop bit on TX_OUT.
- Each bit is held for `prescale` clocks, so TX and RX share clk, prescale, PAR_EN and PAR_TYP configuration.
- Serves as the stimulus source for RX loopback benches.

Parameters:
DATA_WIDTH, 8, payload bits per frame.

Ports:
- clk  in  1  oversampling clock (prescale × baud).
- rst_n  in  1  reset; synchronous, active-low.
- P_DATA  in  DATA_WIDTH  byte to transmit.
- DATA_VALID  in  1  request to send P_DATA.
- PAR_EN  in  1  1 = parity bit inserted.
- PAR_TYP  in  1  1 = odd parity (bit = ~^data), 0 = even parity (bit = ^data).
- prescale  in  6  clocks per bit; legal operating values 8, 16, 32.
- TX_OUT  out  1  serial line; idles high.
- busy  out  1  frame in progress; DATA_VALID is ignored while busy=1.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - TX_OUT=1, busy=0, FSM=IDLE, bit counter=0, clock counter=0, shift register=0.
  - Reset mid-frame aborts the frame at the next edge; no partial stop bit is generated.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept:
  - In IDLE with DATA_VALID=1 at edge N, latch P_DATA, PAR_EN, PAR_TYP and prescale.
  - From edge N: TX_OUT=0, busy=1, state=START. Latency from accept to start-bit edge is 1 clock.
  - Input changes after accept have no effect on the current frame.
- Bit timing:
  - Every bit (start, data, parity, stop) is TX_OUT-stable for exactly latched_prescale clocks.
  - A down-counter loads latched_prescale−1 and advances the FSM on reaching 0.
  - prescale=0 yields 64 clocks per bit (6-bit wrap).
- DATA: 8 bits, LSB first, from the shift register; bit index counts 0..7.
- PARITY:
  - Entered after data bit 7 only when latched PAR_EN=1; otherwise DATA goes directly to STOP.
  - Parity value is computed on the latched byte: PAR_TYP=1 gives ~^data, 0 gives ^data.
- STOP:
  - TX_OUT=1 for latched_prescale clocks, with busy=1 throughout.
  - On the edge ending STOP: state=IDLE, busy=0, TX_OUT stays 1.
- Frame length:
  - 10×prescale clocks without parity; 11×prescale with parity.
  - Minimum inter-frame gap is 1 clock of idle high: DATA_VALID sampled in the first IDLE cycle starts the next frame one edge later.
- DATA_VALID while busy=1 is dropped, not queued; the requester must hold it until busy=0.
- TX_OUT and busy are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package uart_pkg:
  - State encoding enum (IDLE, START, DATA, PARITY, STOP).
  - PAR_ODD=1 / PAR_EVEN=0 constants.
  - Legal prescale constants PRESC_8/16/32, used by both TX and RX.
- One sub-module, uart_tx_bit_timer: 6-bit loadable down-counter with load, enable and tick (count==0) outputs.
- FSM, shift register and parity stay in uart_tx.

Test Plan:
1. prescale=8, PAR_EN=0, P_DATA=8'hA5, one-cycle DATA_VALID → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 clocks; busy high for 80 clocks; start edge 1 clock after accept.
2. prescale=16, PAR_EN=1, PAR_TYP=1, P_DATA=8'h03 → parity bit=1 (odd), frame 176 clocks. Repeat with PAR_TYP=0 → parity bit=0.
3. prescale=32, PAR_EN=1, PAR_TYP=0, P_DATA=8'h07 → parity bit=1; loopback into UART RX gives P_DATA=8'h07, par_err=0, stp_err=0.
4. Pulse DATA_VALID with 8'hFF while busy mid-frame of 8'h00 → second byte not transmitted; TX_OUT idles 1 after the first stop bit. Hold DATA_VALID instead → second frame starts exactly 1 clock after busy falls.
5. Change P_DATA, PAR_EN and prescale during frame → current frame uses latched values unchanged.
6. Assert rst_n=0 for 1 clock during data bit 3 → next edge TX_OUT=1, busy=0; a new DATA_VALID afterwards produces a clean full frame.
